// File: rtl/instr_fetch_prefetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
//   fetch_entry_t : {pc, instr} pair stored in the output FIFO and the PC queue.
//   FETCH_DEPTH   : default FIFO depth / outstanding-request limit.
//   PTR_W         : pointer width for the default depth.
//   NOP_INSTR     : filler written into vacated FIFO slots to ease waveform debug.
package instr_fetch_pkg;

    localparam int unsigned FETCH_DEPTH = 4;
    localparam int unsigned PTR_W       = $clog2(FETCH_DEPTH);
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_prefetch_if.sv
// Bus bundle between the prefetcher, the core and the instruction memory.
//   Core side  : instr_valid_o, instr_rdata_o, instr_addr_o (to core), instr_ready_i (from core).
//   Memory side: mem_req_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o (to memory),
//                mem_rdata_i, mem_rvalid_i (from memory).
// master = prefetcher view, slave = environment (core + memory) view.
interface instr_fetch_prefetch_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic                  instr_valid_o;
    logic [31:0]           instr_rdata_o;
    logic [31:0]           instr_addr_o;
    logic                  instr_ready_i;
    logic                  mem_req_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic                  mem_we_o;
    logic [3:0]            mem_wmask_o;
    logic [31:0]           mem_wdata_o;
    logic [31:0]           mem_rdata_i;
    logic                  mem_rvalid_i;

    modport master (
        output instr_valid_o, instr_rdata_o, instr_addr_o,
        output mem_req_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o,
        input  instr_ready_i, mem_rdata_i, mem_rvalid_i
    );

    modport slave (
        input  instr_valid_o, instr_rdata_o, instr_addr_o,
        input  mem_req_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o,
        output instr_ready_i, mem_rdata_i, mem_rvalid_i
    );
endinterface

// File: rtl/instr_fetch_prefetch_fetch_fifo.sv
// First-word fall-through FIFO of fetch_entry_t with synchronous flush.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   i_flush      : empty the FIFO (wins over push and pop)
//   i_push/i_data: write an entry
//   i_pop        : remove the head (ignored when empty)
//   o_head       : current head entry, straight from storage
//   o_count      : number of stored entries (0..DEPTH)
module fetch_fifo
    import instr_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  fetch_entry_t           i_data,
    input  logic                   i_pop,
    output fetch_entry_t           o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PtrW-1:0] r_rptr;
    logic [PtrW-1:0] r_wptr;
    logic [PtrW:0]   r_count;
    logic [PtrW:0]   w_count_d;
    logic            w_pop;

    assign w_pop = i_pop && (r_count != '0);

    always_comb begin
        w_count_d = r_count;
        if (i_push && !w_pop) begin
            w_count_d = r_count + (PtrW + 1)'(1);
        end else if (!i_push && w_pop) begin
            w_count_d = r_count - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            // Vacated slot gets a NOP; a push into the same slot (full + pop) overrides it.
            if (w_pop) begin
                r_mem[r_rptr] <= fetch_entry_t'{pc: 32'h0, instr: NOP_INSTR};
                r_rptr        <= r_rptr + PtrW'(1);
            end
            if (i_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= r_wptr + PtrW'(1);
            end
            r_count <= w_count_d;
        end
    end

    assign o_head  = r_mem[r_rptr];
    assign o_count = r_count;

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        !(i_push && !i_flush && (r_count == (PtrW + 1)'(DEPTH))));

endmodule

// File: rtl/instr_fetch_prefetch.sv
// Instruction prefetcher: issues word reads to instruction memory, tracks in-flight
// responses, buffers them in order and presents {pc, instr} to the core.
//   clk_i, rst_i   : clock, asynchronous active-high reset
//   branch_i       : one-cycle redirect strobe; flushes buffered and in-flight fetches
//   branch_addr_i  : redirect byte PC (bits [1:0] ignored)
//   io_bus         : core valid/ready port and memory req/addr/rvalid port (master view)
module instr_fetch_prefetch
    import instr_fetch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          branch_i,
    input  logic [31:0]                   branch_addr_i,
    instr_fetch_prefetch_if.master        io_bus
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_d;
    logic [CntW-1:0] r_outstanding;
    logic [CntW-1:0] w_outstanding_d;
    logic [CntW-1:0] r_discard;
    logic [CntW-1:0] w_discard_d;

    logic [CntW-1:0] w_fifo_count;
    logic [CntW-1:0] w_pcq_count;
    logic [CntW:0]   w_occupancy;
    logic            w_issue;
    logic            w_keep;
    logic            w_pop;
    fetch_entry_t    w_fifo_head;
    fetch_entry_t    w_pcq_head;
    fetch_entry_t    w_pcq_push_data;
    fetch_entry_t    w_fifo_push_data;
    logic            w_unused;

    // FIFO slots are reserved at issue time so a response always has room.
    assign w_occupancy = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign w_issue     = !rst_i && !branch_i && (w_occupancy < (CntW + 1)'(DEPTH));
    assign w_keep      = io_bus.mem_rvalid_i && (r_discard == '0) && !branch_i;
    assign w_pop       = io_bus.instr_valid_o && io_bus.instr_ready_i && !branch_i;

    assign w_pcq_push_data  = fetch_entry_t'{pc: r_fetch_pc, instr: 32'h0};
    assign w_fifo_push_data = fetch_entry_t'{pc: w_pcq_head.pc, instr: io_bus.mem_rdata_i};

    always_comb begin
        w_fetch_pc_d    = r_fetch_pc;
        w_outstanding_d = r_outstanding;
        w_discard_d     = r_discard;

        if (branch_i) begin
            w_fetch_pc_d = {branch_addr_i[31:2], 2'b00};
        end else if (w_issue) begin
            w_fetch_pc_d = r_fetch_pc + 32'd4;
        end

        if (w_issue && !io_bus.mem_rvalid_i) begin
            w_outstanding_d = r_outstanding + CntW'(1);
        end else if (!w_issue && io_bus.mem_rvalid_i) begin
            w_outstanding_d = r_outstanding - CntW'(1);
        end

        // On a branch every request still in flight becomes stale, except one that
        // answers in this very cycle (it is dropped right now).
        if (branch_i) begin
            w_discard_d = r_outstanding - CntW'(io_bus.mem_rvalid_i);
        end else if (io_bus.mem_rvalid_i && (r_discard != '0)) begin
            w_discard_d = r_discard - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_pc    <= BOOT_ADDR;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_fetch_pc    <= w_fetch_pc_d;
            r_outstanding <= w_outstanding_d;
            r_discard     <= w_discard_d;
        end
    end

    // PC of each live request, consumed by the matching kept response.
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_flush (branch_i),
        .i_push  (w_issue),
        .i_data  (w_pcq_push_data),
        .i_pop   (w_keep),
        .o_head  (w_pcq_head),
        .o_count (w_pcq_count)
    );

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_instr_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_flush (branch_i),
        .i_push  (w_keep),
        .i_data  (w_fifo_push_data),
        .i_pop   (w_pop),
        .o_head  (w_fifo_head),
        .o_count (w_fifo_count)
    );

    assign w_unused = ^{w_pcq_head.instr, w_pcq_count, branch_addr_i[1:0]};

    assign io_bus.instr_valid_o = (w_fifo_count != '0);
    assign io_bus.instr_rdata_o = w_fifo_head.instr;
    assign io_bus.instr_addr_o  = w_fifo_head.pc;
    assign io_bus.mem_req_o     = w_issue;
    assign io_bus.mem_addr_o    = r_fetch_pc[ADDR_WIDTH+1:2];
    assign io_bus.mem_we_o      = 1'b0;
    assign io_bus.mem_wmask_o   = 4'b0000;
    assign io_bus.mem_wdata_o   = 32'h0;

    a_rvalid_has_request: assert property (@(posedge clk_i) disable iff (rst_i)
        io_bus.mem_rvalid_i |-> (r_outstanding != '0));
    a_discard_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        r_discard <= r_outstanding);

endmodule

// File: tb/tb_instr_fetch_prefetch.sv
module tb_instr_fetch_prefetch;
    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    always #5 clk = ~clk;

    instr_fetch_prefetch_if #(.ADDR_WIDTH(AW)) bus ();

    instr_fetch_prefetch #(
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .BOOT_ADDR  (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .branch_i      (branch_i),
        .branch_addr_i (branch_addr_i),
        .io_bus        (bus)
    );

    // Reference model: words waiting for the core, requests in flight, next fetch PC.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } out_t;
    typedef struct { logic [31:0] pc; bit stale; } flight_t;
    typedef struct { int due; logic [AW-1:0] addr; } rsp_t;

    out_t        m_fifo[$];
    flight_t     m_fl[$];
    rsp_t        mem_q[$];
    logic [31:0] m_pc;
    int          cyc, last_due, lat_lo, lat_hi;
    int          checks, errors, hits;

    function automatic logic [31:0] memword(input logic [AW-1:0] a);
        return 32'h1357_9BDF ^ {a, 8'hA5, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check, let the memory accept, update model.
    // br_mode: 0 no branch, 1 branch, 2 branch only if a response and a core pop coincide.
    task automatic step(input int br_mode, input logic [31:0] baddr, input bit rdy);
        bit      rv, br, exp_req, exp_valid, pop;
        rsp_t    r;
        flight_t f;
        int      due;
        @(negedge clk);
        rv = (mem_q.size() != 0) && (mem_q[0].due == cyc);
        if (rv) begin
            r = mem_q.pop_front();
            bus.mem_rdata_i = memword(r.addr);
        end else begin
            bus.mem_rdata_i = $urandom;
        end
        bus.mem_rvalid_i = rv;
        br = (br_mode == 1) || (br_mode == 2 && rv && rdy && m_fifo.size() != 0);
        if (br && br_mode == 2) hits++;
        branch_i          = br;
        branch_addr_i     = baddr;
        bus.instr_ready_i = rdy;
        #1;
        exp_req   = !br && ((m_fifo.size() + m_fl.size()) < DEPTH);
        exp_valid = (m_fifo.size() != 0);
        chk("mem_req", 32'(bus.mem_req_o), 32'(exp_req));
        if (exp_req) chk("mem_addr", 32'(bus.mem_addr_o), 32'(m_pc[AW+1:2]));
        chk("instr_valid", 32'(bus.instr_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            chk("instr_addr", bus.instr_addr_o, m_fifo[0].pc);
            chk("instr_rdata", bus.instr_rdata_o, m_fifo[0].instr);
        end
        // Memory accepts whatever the DUT actually requests.
        if (bus.mem_req_o) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{due: due, addr: bus.mem_addr_o});
        end
        if (rv && m_fl.size() == 0) chk("rsp_tracked", 32'(m_fl.size()), 32'd1);
        pop = exp_valid && rdy && !br;
        if (br) begin
            m_fifo.delete();
            foreach (m_fl[i]) m_fl[i].stale = 1'b1;
            if (rv && m_fl.size() != 0) void'(m_fl.pop_front());
            m_pc = {baddr[31:2], 2'b00};
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (rv && m_fl.size() != 0) begin
                f = m_fl.pop_front();
                if (!f.stale) m_fifo.push_back('{pc: f.pc, instr: memword(f.pc[AW+1:2])});
            end
            if (exp_req) begin
                m_fl.push_back('{pc: m_pc, stale: 1'b0});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_fl.delete();
        mem_q.delete();
        m_pc     = 32'h0;
        last_due = cyc;
        branch_i = 1'b0;
        bus.mem_rvalid_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd0);
        chk({tag, "_req"},   32'(bus.mem_req_o),     32'd0);
        chk({tag, "_rdata"}, bus.instr_rdata_o,      32'd0);
        chk({tag, "_addr"},  bus.instr_addr_o,       32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; hits = 0; cyc = 0; last_due = 0;
        rst_i = 1'b1; branch_addr_i = 32'h0;
        bus.instr_ready_i = 1'b0; bus.mem_rdata_i = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        chk("reset_we", {27'h0, bus.mem_wmask_o, bus.mem_we_o}, 32'd0);
        rst_i = 1'b0;

        // Streaming, latency 1, core always ready.
        lat_lo = 1; lat_hi = 1;
        repeat (24) step(0, 32'h0, 1'b1);

        // Core stalls: fetching stops once DEPTH words are held/in flight, then resumes.
        repeat (10) step(0, 32'h0, 1'b0);
        chk("stall_full", 32'(m_fifo.size()), 32'(DEPTH));
        repeat (8) step(0, 32'h0, 1'b1);

        // Latency 3, branch to 0x100 while requests are in flight.
        lat_lo = 3; lat_hi = 3;
        repeat (6) step(0, 32'h0, 1'b1);
        step(1, 32'h0000_0101, 1'b1);
        repeat (12) step(0, 32'h0, 1'b1);

        // Branch coinciding with a response and a core pop.
        for (int i = 0; i < 80; i++) step((hits == 0) ? 2 : 0, 32'h0000_0200, 1'($urandom_range(1, 0)));
        chk("branch_rv_pop_seen", 32'(hits != 0), 32'd1);
        repeat (8) step(0, 32'h0, 1'b1);

        // Word-address and 32-bit PC wrap-around.
        lat_lo = 1; lat_hi = 1;
        step(1, 32'h0000_3FFC, 1'b1);
        repeat (10) step(0, 32'h0, 1'b1);
        step(1, 32'hFFFF_FFF8, 1'b1);
        repeat (10) step(0, 32'h0, 1'b1);

        // Random latency, readiness and redirects.
        lat_lo = 1; lat_hi = 4;
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(19, 0) == 0) ? 1 : 0, $urandom, 1'($urandom_range(3, 0) != 0));
        end

        // Asynchronous reset in the middle of a burst.
        lat_lo = 2; lat_hi = 2;
        repeat (5) step(0, 32'h0, 1'b1);
        @(negedge clk);
        #2;
        rst_i = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (12) step(0, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
